// File: rtl/tensor_product_accumulator_pkg.sv
// Shared types and helpers for the tensor product accumulator.
// State encoding, counter width and saturation bounds.
package tensor_product_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int f_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int f_cnt_width(input int n);
    return (f_log2(n) > 0) ? f_log2(n) : 1;
  endfunction

  function automatic logic signed [63:0] f_sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] f_sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/tensor_product_accumulator_tile_mac.sv
// Combinational multiply-accumulate for one TV x TH tile.
// TENSOR_PRODUCT_ACC_SATURATE_EN selects clamp instead of wrap.
module tile_mac
  import tensor_product_accumulator_pkg::*;
#(
  parameter int AW = 8,
  parameter int BW = 8,
  parameter int RW = 8,
  parameter int FW = 4,
  parameter int TV = 1,
  parameter int TH = 1
) (
  input  logic [TV*AW-1:0]    i_a,
  input  logic [TH*BW-1:0]    i_b,
  input  logic [TV*TH*RW-1:0] i_acc,
  output logic [TV*TH*RW-1:0] o_acc,
  output logic [TV*TH-1:0]    o_ovf
);

  localparam int PW = AW + BW;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] S_HI = SW'(f_sat_max(RW));
  localparam logic signed [SW-1:0] S_LO = SW'(f_sat_min(RW));
`ifdef TENSOR_PRODUCT_ACC_SATURATE_EN
  localparam logic [RW-1:0] MAXV = RW'(f_sat_max(RW));
  localparam logic [RW-1:0] MINV = RW'(f_sat_min(RW));
`endif

  for (genvar v = 0; v < TV; v++) begin : g_v
    for (genvar h = 0; h < TH; h++) begin : g_h
      localparam int L = v * TH + h;
      logic signed [PW-1:0] w_prod;
      logic signed [PW-1:0] w_p;
      logic signed [SW-1:0] w_s;
      logic [RW-1:0]        w_acc;
      logic                 w_fit;

      assign w_acc  = i_acc[L*RW+:RW];
      assign w_prod = $signed(i_a[v*AW+:AW]) * $signed(i_b[h*BW+:BW]);
      assign w_p    = w_prod >>> FW;
      assign w_s    = {w_p[PW-1], w_p}
                    + {{(SW-RW){w_acc[RW-1]}}, w_acc};
      assign w_fit  = (w_s >= S_LO) && (w_s <= S_HI);
      assign o_ovf[L] = ~w_fit;
`ifdef TENSOR_PRODUCT_ACC_SATURATE_EN
      assign o_acc[L*RW+:RW] = w_fit ? w_s[RW-1:0]
                             : (w_s[SW-1] ? MINV : MAXV);
`else
      assign o_acc[L*RW+:RW] = w_s[RW-1:0];
`endif
    end
  end

endmodule

// File: rtl/tensor_product_accumulator.sv
// Tiled signed outer-product accumulator over a batch of (a,b) pairs.
// Build option: TENSOR_PRODUCT_ACC_SATURATE_EN (clamp on overflow).
module tensor_product_accumulator
  import tensor_product_accumulator_pkg::*;
#(
  parameter int A_VECTOR_LEN      = 5,
  parameter int B_VECTOR_LEN      = 5,
  parameter int A_CELL_WIDTH      = 8,
  parameter int B_CELL_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 8,
  parameter int FRACTION_WIDTH    = 4,
  parameter int TILING_H          = 1,
  parameter int TILING_V          = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [A_VECTOR_LEN*A_CELL_WIDTH-1:0] a,
  input  logic a_last,
  input  logic a_valid,
  output logic a_ready,
  input  logic [B_VECTOR_LEN*B_CELL_WIDTH-1:0] b,
  input  logic b_valid,
  output logic b_ready,
  output logic [A_VECTOR_LEN*B_VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result,
  output logic result_valid,
  input  logic result_ready,
  output logic error
);

  localparam int AL  = A_VECTOR_LEN;
  localparam int BL  = B_VECTOR_LEN;
  localparam int AW  = A_CELL_WIDTH;
  localparam int BW  = B_CELL_WIDTH;
  localparam int RW  = RESULT_CELL_WIDTH;
  localparam int TV  = TILING_V;
  localparam int TH  = TILING_H;
  localparam int CVN = (AL + TV - 1) / TV;
  localparam int CHN = (BL + TH - 1) / TH;
  localparam int CW  = f_cnt_width(CVN > CHN ? CVN : CHN);
  localparam logic [CW-1:0] CV_LAST = CW'(CVN - 1);
  localparam logic [CW-1:0] CH_LAST = CW'(CHN - 1);

  state_t              r_state, w_next;
  logic [AL*AW-1:0]    r_a;
  logic [BL*BW-1:0]    r_b;
  logic                r_a_last, r_a_set, r_b_set;
  logic [CW-1:0]       r_cv, r_ch;
  logic [AL*BL*RW-1:0] r_acc;
  logic                r_err;

  logic [TV*AW-1:0]    w_ta;
  logic [TH*BW-1:0]    w_tb;
  logic [TV*TH*RW-1:0] w_tacc, w_nacc;
  logic [TV*TH-1:0]    w_mask, w_ovf;
  logic                w_ch_end, w_calc_end;

  assign w_ch_end   = (r_ch == CH_LAST);
  assign w_calc_end = w_ch_end && (r_cv == CV_LAST);

  assign a_ready      = (r_state == IDLE) && !r_a_set;
  assign b_ready      = (r_state == IDLE) && !r_b_set;
  assign result_valid = (r_state == DONE);
  assign result       = r_acc;
  assign error        = r_err;

  // Padded lanes beyond the vector ends read zero and are masked off.
  always_comb begin
    w_ta   = '0;
    w_tb   = '0;
    w_tacc = '0;
    w_mask = '0;
    for (int v = 0; v < TV; v++)
      if (int'(r_cv) * TV + v < AL)
        w_ta[v*AW+:AW] = r_a[(int'(r_cv)*TV+v)*AW+:AW];
    for (int h = 0; h < TH; h++)
      if (int'(r_ch) * TH + h < BL)
        w_tb[h*BW+:BW] = r_b[(int'(r_ch)*TH+h)*BW+:BW];
    for (int v = 0; v < TV; v++)
      for (int h = 0; h < TH; h++)
        if ((int'(r_cv) * TV + v < AL) && (int'(r_ch) * TH + h < BL)) begin
          w_mask[v*TH+h] = 1'b1;
          w_tacc[(v*TH+h)*RW+:RW] =
            r_acc[((int'(r_cv)*TV+v)*BL+int'(r_ch)*TH+h)*RW+:RW];
        end
  end

  tile_mac #(
    .AW(AW), .BW(BW), .RW(RW), .FW(FRACTION_WIDTH), .TV(TV), .TH(TH)
  ) u_mac (
    .i_a  (w_ta),
    .i_b  (w_tb),
    .i_acc(w_tacc),
    .o_acc(w_nacc),
    .o_ovf(w_ovf)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (r_a_set && r_b_set) w_next = CALC;
      CALC: if (w_calc_end) w_next = r_a_last ? DONE : IDLE;
      DONE: if (result_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_a_last <= 1'b0;
      r_a_set  <= 1'b0;
      r_b_set  <= 1'b0;
      r_cv     <= '0;
      r_ch     <= '0;
      r_acc    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: begin
          if (a_valid && !r_a_set) begin
            r_a      <= a;
            r_a_last <= a_last;
            r_a_set  <= 1'b1;
          end
          if (b_valid && !r_b_set) begin
            r_b     <= b;
            r_b_set <= 1'b1;
          end
          r_cv <= '0;
          r_ch <= '0;
        end
        CALC: begin
          for (int v = 0; v < TV; v++)
            for (int h = 0; h < TH; h++)
              if (w_mask[v*TH+h])
                r_acc[((int'(r_cv)*TV+v)*BL+int'(r_ch)*TH+h)*RW+:RW]
                  <= w_nacc[(v*TH+h)*RW+:RW];
          if (|(w_ovf & w_mask)) r_err <= 1'b1;
          if (w_ch_end) begin
            r_ch <= '0;
            r_cv <= w_calc_end ? '0 : r_cv + CW'(1);
          end else begin
            r_ch <= r_ch + CW'(1);
          end
          if (w_calc_end && !r_a_last) begin
            r_a_set <= 1'b0;
            r_b_set <= 1'b0;
          end
        end
        DONE: begin
          if (result_ready) begin
            r_acc   <= '0;
            r_err   <= 1'b0;
            r_a_set <= 1'b0;
            r_b_set <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_product_accumulator.sv
// Directed bench: 2x2 instance for batch behaviour, 5x3 tiled instance.
module tb_tensor_product_accumulator;

`ifdef TENSOR_PRODUCT_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] a, b;
  logic        a_last, a_valid, a_ready, b_valid, b_ready;
  logic [31:0] result;
  logic        result_valid, result_ready, error;

  logic [39:0]  ta;
  logic [23:0]  tb;
  logic         ta_last, ta_valid, ta_ready, tb_valid, tb_ready;
  logic [119:0] tresult;
  logic         tresult_valid, tresult_ready, terror;

  tensor_product_accumulator #(
    .A_VECTOR_LEN(2), .B_VECTOR_LEN(2), .A_CELL_WIDTH(8), .B_CELL_WIDTH(8),
    .RESULT_CELL_WIDTH(8), .FRACTION_WIDTH(4), .TILING_H(1), .TILING_V(1)
  ) dut (
    .clk(clk), .rst(rst), .a(a), .a_last(a_last), .a_valid(a_valid),
    .a_ready(a_ready), .b(b), .b_valid(b_valid), .b_ready(b_ready),
    .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .error(error)
  );

  tensor_product_accumulator #(
    .A_VECTOR_LEN(5), .B_VECTOR_LEN(3), .A_CELL_WIDTH(8), .B_CELL_WIDTH(8),
    .RESULT_CELL_WIDTH(8), .FRACTION_WIDTH(4), .TILING_H(2), .TILING_V(2)
  ) dut_t (
    .clk(clk), .rst(rst), .a(ta), .a_last(ta_last), .a_valid(ta_valid),
    .a_ready(ta_ready), .b(tb), .b_valid(tb_valid), .b_ready(tb_ready),
    .result(tresult), .result_valid(tresult_valid),
    .result_ready(tresult_ready), .error(terror)
  );

  typedef struct {
    int a0, a1, b0, b1;
    bit last;
    int e[4];
    bit err;
  } vec_t;

  vec_t vt[9];
  int   n_tests = 0;
  int   n_fail  = 0;
  localparam logic [31:0] EXP1 = 32'hE020F010;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input int a0, a1, b0, b1, input bit last);
    a       = {8'(a1), 8'(a0)};
    b       = {8'(b1), 8'(b0)};
    a_last  = last;
    a_valid = 1'b1;
    b_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic wait_res(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!result_valid && cnt < 30);
  endtask

  task automatic release_res();
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk("ready_back", {a_ready, b_ready, result_valid, error}, 4'b1100);
  endtask

  function automatic vec_t mk(int a0, a1, b0, b1, bit last,
                              int e0, e1, e2, e3, bit err);
    vec_t r;
    r.a0 = a0; r.a1 = a1; r.b0 = b0; r.b1 = b1; r.last = last;
    r.e[0] = e0; r.e[1] = e1; r.e[2] = e2; r.e[3] = e3; r.err = err;
    return r;
  endfunction

  initial begin
    int   cnt;
    bit   saw;
    int   av[5];
    int   bv[3];
    logic [7:0] ex;

    vt[0] = mk(16, 32, 16, -16, 1, 16, -16, 32, -32, 0);
    vt[1] = mk(16, 32, 16, -16, 0, 0, 0, 0, 0, 0);
    vt[2] = mk(16, 32, 16, -16, 1, 32, -32, 64, -64, 0);
    vt[3] = mk(127, 0, 127, 0, 1, SAT ? 127 : -16, 0, 0, 0, 1);
    vt[4] = mk(-1, 8, 1, -24, 1, -1, 1, 0, -12, 0);
    vt[5] = mk(-128, 16, 16, -128, 1, -128, SAT ? 127 : 0, 16, -128, 1);
    vt[6] = mk(64, 0, 16, 0, 0, 0, 0, 0, 0, 0);
    vt[7] = mk(64, 0, 16, 0, 1, SAT ? 127 : -128, 0, 0, 0, 1);
    vt[8] = mk(-128, 0, 32, 0, 1, SAT ? -128 : 0, 0, 0, 0, 1);

    rst = 1'b1;
    a = '0; b = '0; a_last = 0; a_valid = 0; b_valid = 0; result_ready = 0;
    ta = '0; tb = '0; ta_last = 0; ta_valid = 0; tb_valid = 0;
    tresult_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_flags", {a_ready, b_ready, result_valid, error}, 4'b1100);
    chk("rst_result", result, 32'h0);

    for (int i = 0; i < 9; i++) begin
      send(vt[i].a0, vt[i].a1, vt[i].b0, vt[i].b1, vt[i].last);
      if (vt[i].last) begin
        wait_res(cnt);
        chk($sformatf("v%0d_latency", i), cnt, 5);
        for (int k = 0; k < 4; k++)
          chk($sformatf("v%0d_cell%0d", i, k), result[k*8+:8],
              vt[i].e[k] & 32'hFF);
        chk($sformatf("v%0d_error", i), error, vt[i].err);
        release_res();
      end else begin
        cnt = 0;
        saw = 0;
        do begin
          @(posedge clk); #1;
          cnt++;
          saw |= result_valid;
        end while (!(a_ready && b_ready) && cnt < 30);
        chk($sformatf("v%0d_idle_ret", i), cnt, 5);
        chk($sformatf("v%0d_no_valid", i), saw, 1'b0);
      end
    end

    // Back-pressure: DONE holds everything until result_ready.
    send(16, 32, 16, -16, 1);
    wait_res(cnt);
    chk("bp_latency", cnt, 5);
    for (int c = 0; c < 10; c++) begin
      chk("bp_hold_result", result, EXP1);
      chk("bp_hold_flags", {result_valid, a_ready, b_ready, error}, 4'b1000);
      @(posedge clk); #1;
    end
    release_res();
    send(16, 32, 16, -16, 1);
    wait_res(cnt);
    chk("bp_next_batch", result, EXP1);
    release_res();

    // Reset in the middle of CALC.
    send(127, 0, 127, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_calc_err", {error, result_valid, a_ready}, 3'b100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_flags", {a_ready, b_ready, result_valid, error}, 4'b1100);
    chk("mid_rst_result", result, 32'h0);
    send(16, 32, 16, -16, 1);
    wait_res(cnt);
    chk("post_rst_latency", cnt, 5);
    chk("post_rst_result", result, EXP1);
    chk("post_rst_error", error, 1'b0);
    release_res();

    // Tiled 5x3 instance with 2x2 tiles: 6 CALC cycles.
    av = '{16, -32, 48, 8, -16};
    bv = '{16, 32, -8};
    for (int i = 0; i < 5; i++) ta[i*8+:8] = 8'(av[i]);
    for (int j = 0; j < 3; j++) tb[j*8+:8] = 8'(bv[j]);
    ta_last = 1'b1;
    ta_valid = 1'b1;
    tb_valid = 1'b1;
    @(posedge clk); #1;
    ta_valid = 1'b0;
    tb_valid = 1'b0;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!tresult_valid && cnt < 30);
    chk("tile_latency", cnt, 7);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 3; j++) begin
        ex = 8'((av[i] * bv[j]) >>> 4);
        chk($sformatf("tile_cell_%0d_%0d", i, j), tresult[(i*3+j)*8+:8], ex);
      end
    chk("tile_error", terror, 1'b0);
    chk("tile_ready", {ta_ready, tb_ready}, 2'b00);
    tresult_ready = 1'b1;
    @(posedge clk); #1;
    tresult_ready = 1'b0;
    chk("tile_back_idle", {ta_ready, tb_ready, tresult_valid}, 3'b110);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
